// File: rtl/cat_recognizer_pkg.sv
// -----------------------------------------------------------------------------
// cat_recognizer_pkg
// Shared constants, the scoring FSM state type and the per-lane multiply
// helper used by the cat score engine.
// -----------------------------------------------------------------------------
package cat_recognizer_pkg;

    localparam int NUM_IMG_WORDS    = 4096;  // image words per frame
    localparam int FIRST_PIXEL_ADDR = 1;     // pixel words live at 1..NUM_IMG_WORDS
    localparam int ACC_W            = 64;    // accumulator / score width
    localparam int PROD_W           = 32;    // width of one lane product

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        DECIDE = 2'd3
    } cat_state_e;

    // Unsigned 8-bit pixel times an already sign-extended weight.
    function automatic logic signed [PROD_W-1:0] lane_product(
        input logic        [7:0]        pix,
        input logic signed [PROD_W-1:0] w_ext
    );
        logic signed [PROD_W-1:0] pix_ext;
        pix_ext      = $signed({{(PROD_W-8){1'b0}}, pix});
        lane_product = pix_ext * w_ext;
    endfunction

endpackage

// File: rtl/pixel_weight_mac.sv
// -----------------------------------------------------------------------------
// pixel_weight_mac
// Combinational 3-lane dot product of one pixel word and one weight word.
// Pixel lanes are unsigned bytes; weight lanes are signed Weight_precision-bit
// values. The result is sign-extended to the accumulator width.
//   pixel   : Amba_Word-bit pixel word, lanes [7:0], [15:8], [23:16]
//   weights : 3*Weight_precision packed signed weights, lane 0 in the LSBs
//   dot     : signed ACC_W-bit sum of the three lane products
// -----------------------------------------------------------------------------
module pixel_weight_mac
    import cat_recognizer_pkg::*;
#(
    parameter int Amba_Word        = 24,
    parameter int Weight_precision = 5
) (
    input  logic        [Amba_Word-1:0]          pixel,
    input  logic        [3*Weight_precision-1:0] weights,
    output logic signed [ACC_W-1:0]              dot
);

    // Sum of the three lane products, each computed at PROD_W bits.
    always_comb begin : mac_sum
        logic signed [Weight_precision-1:0] w_lane_s;
        logic signed [PROD_W-1:0]           prod_s;
        dot      = {ACC_W{1'b0}};
        w_lane_s = {Weight_precision{1'b0}};
        prod_s   = {PROD_W{1'b0}};
        for (int i = 0; i < 3; i++) begin
            w_lane_s = $signed(weights[i*Weight_precision +: Weight_precision]);
            prod_s   = lane_product(pixel[i*8 +: 8], PROD_W'(w_lane_s));
            dot      = dot + ACC_W'(prod_s);
        end
    end

endmodule

// File: rtl/cat_score_engine.sv
// -----------------------------------------------------------------------------
// cat_score_engine
// Streams one frame of pixel words and their weights out of two synchronous
// read ports, accumulates the per-word dot products and decides "cat" when the
// final score is strictly positive.
//
// Optional feature: define CAT_REC_BIAS_EN to add a signed 32-bit bias port
// that is added to the accumulated sum when the final score is formed
// (acc_val itself never contains the bias).
//
// Ports
//   clk, rst     : clock, asynchronous active-low reset
//   start        : one-cycle request to score the stored frame (ignored while busy)
//   reg_rd_addr  : pixel word address, 1..Num_Words while fetching, else 0
//   reg_rd_data  : pixel word, valid one cycle after its address
//   w_rd_addr    : weight address, always reg_rd_addr-1 while fetching, else 0
//   w_rd_data    : packed channel weights, valid one cycle after its address
//   bias         : (CAT_REC_BIAS_EN only) signed score bias
//   busy         : frame scoring in progress
//   acc_val      : signed running accumulator
//   last_result  : signed final score of the last completed frame
//   CatRecOut    : 1 when last_result > 0
//   done         : one-cycle completion pulse
// -----------------------------------------------------------------------------
module cat_score_engine
    import cat_recognizer_pkg::*;
#(
    parameter int Amba_Word        = 24,
    parameter int Amba_Addr_Depth  = 13,
    parameter int Weight_precision = 5,
    parameter int Num_Words        = NUM_IMG_WORDS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic        [Amba_Addr_Depth-1:0] reg_rd_addr,
    input  logic        [Amba_Word-1:0]       reg_rd_data,
    output logic        [Amba_Addr_Depth-1:0] w_rd_addr,
    input  logic        [3*Weight_precision-1:0] w_rd_data,
`ifdef CAT_REC_BIAS_EN
    input  logic signed [31:0]                bias,
`endif
    output logic                            busy,
    output logic signed [ACC_W-1:0]         acc_val,
    output logic signed [ACC_W-1:0]         last_result,
    output logic                            CatRecOut,
    output logic                            done
);

    localparam logic [Amba_Addr_Depth-1:0] ADDR_ZERO  = {Amba_Addr_Depth{1'b0}};
    localparam logic [Amba_Addr_Depth-1:0] FIRST_ADDR = Amba_Addr_Depth'(FIRST_PIXEL_ADDR);
    localparam logic [Amba_Addr_Depth-1:0] LAST_ADDR  = Amba_Addr_Depth'(Num_Words);

    cat_state_e                   state_r;
    logic [Amba_Addr_Depth-1:0]   reg_rd_addr_r;   // doubles as the word counter
    logic [Amba_Addr_Depth-1:0]   w_rd_addr_r;
    logic                         data_vld_r;      // read data on the ports belongs to this frame
    logic                         busy_r;
    logic signed [ACC_W-1:0]      acc_val_r;
    logic signed [ACC_W-1:0]      last_result_r;
    logic                         cat_rec_r;
    logic                         done_r;
    logic signed [ACC_W-1:0]      dot_s;
    logic signed [ACC_W-1:0]      score_s;
    logic                         score_pos_s;

    pixel_weight_mac #(
        .Amba_Word        (Amba_Word),
        .Weight_precision (Weight_precision)
    ) u_mac (
        .pixel   (reg_rd_data),
        .weights (w_rd_data),
        .dot     (dot_s)
    );

    // Final score: accumulated sum, optionally biased; positive means strictly > 0.
    always_comb begin
`ifdef CAT_REC_BIAS_EN
        score_s = acc_val_r + ACC_W'(bias);
`else
        score_s = acc_val_r;
`endif
        score_pos_s = !score_s[ACC_W-1] && (score_s != {ACC_W{1'b0}});
    end

    // Scoring FSM: address generation, accumulation and decision registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            reg_rd_addr_r <= ADDR_ZERO;
            w_rd_addr_r   <= ADDR_ZERO;
            data_vld_r    <= 1'b0;
            busy_r        <= 1'b0;
            acc_val_r     <= {ACC_W{1'b0}};
            last_result_r <= {ACC_W{1'b0}};
            cat_rec_r     <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            // An address issued in FETCH returns data one cycle later.
            data_vld_r <= (state_r == FETCH);
            if (data_vld_r) begin
                acc_val_r <= acc_val_r + dot_s;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r       <= FETCH;
                        busy_r        <= 1'b1;
                        acc_val_r     <= {ACC_W{1'b0}};
                        cat_rec_r     <= 1'b0;
                        reg_rd_addr_r <= FIRST_ADDR;
                        w_rd_addr_r   <= FIRST_ADDR - 1'b1;
                    end else begin
                        state_r       <= IDLE;
                    end
                end
                FETCH: begin
                    if (reg_rd_addr_r == LAST_ADDR) begin
                        state_r       <= DRAIN;
                        reg_rd_addr_r <= ADDR_ZERO;
                        w_rd_addr_r   <= ADDR_ZERO;
                    end else begin
                        reg_rd_addr_r <= reg_rd_addr_r + 1'b1;
                        w_rd_addr_r   <= reg_rd_addr_r;
                    end
                end
                DRAIN: begin
                    state_r <= DECIDE;
                end
                DECIDE: begin
                    last_result_r <= score_s;
                    cat_rec_r     <= score_pos_s;
                    done_r        <= 1'b1;
                    busy_r        <= 1'b0;
                    state_r       <= IDLE;
                end
                default: begin
                    state_r       <= IDLE;
                    busy_r        <= 1'b0;
                    reg_rd_addr_r <= ADDR_ZERO;
                    w_rd_addr_r   <= ADDR_ZERO;
                end
            endcase
        end
    end

    assign reg_rd_addr = reg_rd_addr_r;
    assign w_rd_addr   = w_rd_addr_r;
    assign busy        = busy_r;
    assign acc_val     = acc_val_r;
    assign last_result = last_result_r;
    assign CatRecOut   = cat_rec_r;
    assign done        = done_r;

endmodule

// File: tb/tb_cat_score_engine.sv
// -----------------------------------------------------------------------------
// tb_cat_score_engine
// Directed bench for cat_score_engine. A synchronous-read memory model returns
// pixel and weight words one cycle after their addresses; the data pattern is
// chosen by 'mode'. Expected scores are hand-computed constants or a reference
// sum built by the bench from the same data pattern.
// -----------------------------------------------------------------------------
module tb_cat_score_engine;

    logic               clk;
    logic               rst;
    logic               start;
    logic [12:0]        reg_rd_addr;
    logic [23:0]        reg_rd_data;
    logic [12:0]        w_rd_addr;
    logic [14:0]        w_rd_data;
    logic               busy;
    logic signed [63:0] acc_val;
    logic signed [63:0] last_result;
    logic               cat_rec_out;
    logic               done;
    logic signed [31:0] bias;

    int n_checks = 0;
    int n_err    = 0;
    int mode     = 0;

    cat_score_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .w_rd_addr   (w_rd_addr),
        .w_rd_data   (w_rd_data),
`ifdef CAT_REC_BIAS_EN
        .bias        (bias),
`endif
        .busy        (busy),
        .acc_val     (acc_val),
        .last_result (last_result),
        .CatRecOut   (cat_rec_out),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pix_f(input int m, input logic [12:0] a);
        case (m)
            0:       pix_f = 24'h010101;
            1:       pix_f = 24'hFFFFFF;
            2:       pix_f = 24'h000000;
            4:       pix_f = (a == 13'd1) ? 24'h000064 : 24'h000000;
            default: pix_f = {a[7:0], a[7:0] ^ 8'h5A, 3'b000, a[12:8]};
        endcase
    endfunction

    function automatic logic [14:0] wt_f(input int m, input logic [12:0] a);
        case (m)
            0:       wt_f = {5'd1, 5'd1, 5'd1};
            1:       wt_f = {5'b10000, 5'b10000, 5'b10000};
            2:       wt_f = {a[4:0], a[9:5], a[4:0] ^ 5'h11};
            4:       wt_f = {5'd0, 5'd0, 5'd1};
            default: wt_f = {a[4:0], a[9:5], a[2:0], 2'b01};
        endcase
    endfunction

    // Synchronous-read memories: data follows the address by one cycle.
    always @(posedge clk) begin
        reg_rd_data <= pix_f(mode, reg_rd_addr);
        w_rd_data   <= wt_f(mode, w_rd_addr);
    end

    function automatic longint dot_ref(input logic [23:0] p, input logic [14:0] w);
        longint s;
        logic signed [4:0] ws;
        s = 0;
        for (int j = 0; j < 3; j++) begin
            ws = w[5*j +: 5];
            s  = s + longint'(p[8*j +: 8]) * longint'(ws);
        end
        return s;
    endfunction

    // Pixel word k is paired with weight word k-1.
    function automatic longint frame_ref(input int m);
        longint s;
        s = 0;
        for (int k = 1; k <= 4096; k++) begin
            s = s + dot_ref(pix_f(m, 13'(k)), wt_f(m, 13'(k - 1)));
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_frame(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_raddr"}, 64'(reg_rd_addr), 64'd1);
        chk({tag, "_waddr"}, 64'(w_rd_addr), 64'd0);
        chk({tag, "_acc0"}, acc_val, 64'd0);
        chk({tag, "_cat0"}, 64'(cat_rec_out), 64'd0);
    endtask

    task automatic wait_frame(input bit inj, input bit chain, output int done_at,
                              output int done_cnt, output logic [63:0] acc_at2,
                              output logic [63:0] state_at_done);
        done_at       = 0;
        done_cnt      = 0;
        acc_at2       = 64'd0;
        state_at_done = 64'd0;
        for (int i = 1; i <= 4110; i++) begin
            @(negedge clk);
            start = (inj && (i == 10 || i == 4000)) ? 1'b1 : 1'b0;
            if (i == 2) acc_at2 = acc_val;
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at       = i;
                    state_at_done = {38'd0, busy, reg_rd_addr, w_rd_addr};
                end
                if (chain) begin
                    start = 1'b1;
                    break;
                end
            end
        end
    endtask

    int          d_at;
    int          d_cnt;
    logic [63:0] a2;
    logic [63:0] st;
    longint      ref3;
    int          late_done;

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        bias  = 32'sd0;
        ref3  = frame_ref(3);
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cat", 64'(cat_rec_out), 64'd0);
        chk("rst_acc", acc_val, 64'd0);
        chk("rst_last", last_result, 64'd0);
        chk("rst_addr", {38'd0, reg_rd_addr, w_rd_addr}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // All 0xFF pixels with weight -16 per lane.
        mode = 1;
        start_frame("m1");
        wait_frame(1'b0, 1'b0, d_at, d_cnt, a2, st);
        chk("m1_last", last_result, -64'sd50135040);
        chk("m1_cat", 64'(cat_rec_out), 64'd0);
        chk("m1_done_at", 64'(d_at), 64'd4098);
        chk("m1_done_cnt", 64'(d_cnt), 64'd1);

        // All 0x010101 pixels with weight +1 per lane.
        mode = 0;
        start_frame("m0");
        wait_frame(1'b0, 1'b0, d_at, d_cnt, a2, st);
        chk("m0_acc_word1", a2, 64'd3);
        chk("m0_acc", acc_val, 64'd12288);
        chk("m0_last", last_result, 64'd12288);
        chk("m0_cat", 64'(cat_rec_out), 64'd1);
        chk("m0_done_at", 64'(d_at), 64'd4098);
        chk("m0_done_cnt", 64'(d_cnt), 64'd1);
        chk("m0_done_state", st, 64'd0);

        // Start keeps last_result; reset mid-frame abandons the frame.
        mode = 3;
        start_frame("abort");
        chk("abort_last_held", last_result, 64'd12288);
        repeat (2000) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_cat", 64'(cat_rec_out), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_acc", acc_val, 64'd0);
        chk("arst_last", last_result, 64'd0);
        chk("arst_addr", {38'd0, reg_rd_addr, w_rd_addr}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_cat_hold", 64'(cat_rec_out), 64'd0);
        end
        rst       = 1'b1;
        late_done = 0;
        for (int i = 0; i < 4200; i++) begin
            @(negedge clk);
            if (done) late_done++;
        end
        chk("abort_no_done", 64'(late_done), 64'd0);

        mode = 3;
        start_frame("m3");
        wait_frame(1'b0, 1'b0, d_at, d_cnt, a2, st);
        chk("m3_acc", acc_val, ref3);
        chk("m3_last", last_result, ref3);
        chk("m3_cat", 64'(cat_rec_out), 64'(ref3 > 0));
        chk("m3_done_at", 64'(d_at), 64'd4098);

        // Extra start pulses while busy are ignored; chain a start on done.
        start_frame("inj");
        wait_frame(1'b1, 1'b1, d_at, d_cnt, a2, st);
        chk("inj_last", last_result, ref3);
        chk("inj_done_at", 64'(d_at), 64'd4098);
        chk("inj_done_cnt", 64'(d_cnt), 64'd1);

        mode = 2;
        start_frame("chain");
        wait_frame(1'b0, 1'b0, d_at, d_cnt, a2, st);
        chk("zero_last", last_result, 64'd0);
        chk("zero_cat", 64'(cat_rec_out), 64'd0);
        chk("zero_done_at", 64'(d_at), 64'd4098);

`ifdef CAT_REC_BIAS_EN
        mode = 4;
        bias = -32'sd100;
        start_frame("bias100");
        wait_frame(1'b0, 1'b0, d_at, d_cnt, a2, st);
        chk("bias100_acc", acc_val, 64'd100);
        chk("bias100_last", last_result, 64'd0);
        chk("bias100_cat", 64'(cat_rec_out), 64'd0);
        bias = -32'sd99;
        start_frame("bias99");
        wait_frame(1'b0, 1'b0, d_at, d_cnt, a2, st);
        chk("bias99_last", last_result, 64'd1);
        chk("bias99_cat", 64'(cat_rec_out), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
